// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
// Package     : whack_pkg
// Description : Shared definitions for the whack-a-mole board: game state
//               encoding, LFSR seed/tap mask and small arithmetic helpers.
//               Used by the scheduler, display and debounce blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package whack_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_GAP  = ST_GAP,
        S_SHOW = ST_SHOW,
        S_DONE = ST_DONE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Saturating 8-bit increment: sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_tick.sv
`default_nettype none
// ============================================================================
// Module      : game_tick
// Description : Game tick divider. Counts 0..TICK_DIV-1 while enabled and
//               raises o_tick for the single cycle the count is TICK_DIV-1.
//               i_clear restarts the count so a new phase starts aligned.
// Ports       : clk_in    - system clock
//               rst       - asynchronous active-high reset
//               i_clear   - synchronous restart of the count
//               i_enable  - count enable (game busy)
//               o_tick    - one-cycle tick enable
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tick = i_enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mole_scheduler
// Description : Whack-a-mole game sequencer. Lights one pseudo-random mole at
//               a time, scores debounced button hits and counts misses over
//               ROUNDS moles. Timing comes from one-cycle tick enables.
// Ports       : clk_in     - system clock
//               rst        - asynchronous active-high reset
//               start      - one-cycle pulse, starts a game from IDLE/DONE
//               btn        - debounced press pulses, one bit per hole
//               led        - one-hot mole display, zero when dark
//               score/miss - saturating 8-bit hit and miss counts
//               hit_pulse  - one-cycle pulse per scored hit
//               busy/done  - game running / game finished
// Config      : `define SPEEDUP_EN shortens the mole time by one tick every
//               four rounds (floored at one tick).
// Revision    : 1.0 - initial release
// ============================================================================
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int NUM_HOLES  = 4,
    parameter int TICK_DIV   = 22_000_000,
    parameter int MOLE_TICKS = 3,
    parameter int GAP_TICKS  = 1,
    parameter int ROUNDS     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] btn,
    output logic [NUM_HOLES-1:0] led,
    output logic [7:0]           score,
    output logic [7:0]           miss,
    output logic                 hit_pulse,
    output logic                 busy,
    output logic                 done
);

    localparam int HW = $clog2(NUM_HOLES);
    localparam logic [NUM_HOLES-1:0] c_one        = NUM_HOLES'(1);
    localparam logic [7:0]           c_mole_ticks = 8'(MOLE_TICKS);
    localparam logic [7:0]           c_gap_ticks  = 8'(GAP_TICKS);
    localparam logic [7:0]           c_last_round = 8'(ROUNDS - 1);

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_lfsr;
    logic [HW-1:0]   r_hole, w_hole_nxt;
    logic [HW-1:0]   r_prev, w_prev_nxt;
    logic [7:0]      r_round, w_round_nxt;
    logic [7:0]      r_timer, w_timer_nxt;
    logic [NUM_HOLES-1:0] w_led_nxt;
    logic [7:0]      w_score_nxt, w_miss_nxt;
    logic            w_hit_pulse_nxt;
    logic            w_clear;
    logic            w_tick;
    logic            w_expire;
    logic            w_hit;
    logic            w_wrong;
    logic [HW-1:0]   w_cand;
    logic [HW-1:0]   w_pick;
    logic [7:0]      w_show_ticks;

    game_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_in   (clk_in),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (busy),
        .o_tick   (w_tick)
    );

    // Phase timer holds ticks remaining; the phase ends on the tick that
    // would take it from 1 to 0.
    assign w_expire = w_tick && (r_timer == 8'd1);

    assign w_hit   = btn[r_hole];
    assign w_wrong = |(btn & ~(c_one << r_hole));

    // Bumping a repeated candidate by one (mod NUM_HOLES, a power of two)
    // guarantees consecutive moles differ.
    assign w_cand = r_lfsr[HW-1:0];
    assign w_pick = (w_cand == r_prev) ? w_cand + 1'b1 : w_cand;

`ifdef SPEEDUP_EN
    logic [7:0] w_speed_dec;
    assign w_speed_dec  = {2'b00, r_round[7:2]};
    assign w_show_ticks = (w_speed_dec >= c_mole_ticks) ? 8'd1
                                                        : c_mole_ticks - w_speed_dec;
`else
    assign w_show_ticks = c_mole_ticks;
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_hole    <= '0;
            r_prev    <= '0;
            r_round   <= '0;
            r_timer   <= '0;
            led       <= '0;
            score     <= '0;
            miss      <= '0;
            hit_pulse <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Free-running in every state so the start instant seeds the game
            r_lfsr    <= lfsr_next(r_lfsr);
            r_hole    <= w_hole_nxt;
            r_prev    <= w_prev_nxt;
            r_round   <= w_round_nxt;
            r_timer   <= w_timer_nxt;
            led       <= w_led_nxt;
            score     <= w_score_nxt;
            miss      <= w_miss_nxt;
            hit_pulse <= w_hit_pulse_nxt;
            busy      <= (w_state_nxt == S_GAP) || (w_state_nxt == S_SHOW);
            done      <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hole_nxt      = r_hole;
        w_prev_nxt      = r_prev;
        w_round_nxt     = r_round;
        w_timer_nxt     = r_timer;
        w_led_nxt       = led;
        w_score_nxt     = score;
        w_miss_nxt      = miss;
        w_hit_pulse_nxt = 1'b0;
        w_clear         = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_led_nxt = '0;
                if (start) begin
                    w_state_nxt = S_GAP;
                    w_score_nxt = '0;
                    w_miss_nxt  = '0;
                    w_round_nxt = '0;
                    w_prev_nxt  = '0;
                    w_timer_nxt = c_gap_ticks;
                    w_clear     = 1'b1;
                end
            end

            S_GAP: begin
                w_led_nxt = '0;
                if (w_expire) begin
                    w_state_nxt = S_SHOW;
                    w_hole_nxt  = w_pick;
                    w_prev_nxt  = w_pick;
                    w_led_nxt   = c_one << w_pick;
                    w_timer_nxt = w_show_ticks;
                    w_clear     = 1'b1;
                end else if (w_tick) begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end

            S_SHOW: begin
                // A correct press overrides both wrong presses and expiry
                if (w_hit) begin
                    w_score_nxt     = sat_inc(score);
                    w_hit_pulse_nxt = 1'b1;
                    w_led_nxt       = '0;
                end else begin
                    if (w_wrong || w_expire) begin
                        w_miss_nxt = sat_inc(miss);
                    end
                    if (w_expire) begin
                        w_led_nxt = '0;
                    end else if (w_tick) begin
                        w_timer_nxt = r_timer - 8'd1;
                    end
                end

                if (w_hit || w_expire) begin
                    w_round_nxt = r_round + 8'd1;
                    if (r_round == c_last_round) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_timer_nxt = c_gap_ticks;
                        w_clear     = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_scheduler
// Description : Self-checking bench for mole_scheduler with TICK_DIV=4,
//               MOLE_TICKS=3, GAP_TICKS=1, NUM_HOLES=4 and ROUNDS=4
//               (ROUNDS=8 when SPEEDUP_EN is defined). The expected hole
//               sequence is derived from the LFSR polynomial and the number
//               of clock edges since reset; phase lengths from tick arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_scheduler;

`ifdef SPEEDUP_EN
    localparam int ROUNDS = 8;
`else
    localparam int ROUNDS = 4;
`endif
    localparam int TICK_DIV   = 4;
    localparam int MOLE_TICKS = 3;
    localparam int GAP_TICKS  = 1;
    localparam int NH         = 4;

    logic          clk_in = 1'b0;
    logic          rst    = 1'b1;
    logic          start  = 1'b0;
    logic [NH-1:0] btn    = '0;
    logic [NH-1:0] led;
    logic [7:0]    score;
    logic [7:0]    miss;
    logic          hit_pulse;
    logic          busy;
    logic          done;

    int          vectors = 0;
    int          errors  = 0;
    int unsigned cyc;

    int exp_score;
    int exp_miss;
    int prev_hole;
    logic [NH-1:0] last_led;

    mole_scheduler #(
        .NUM_HOLES  (NH),
        .TICK_DIV   (TICK_DIV),
        .MOLE_TICKS (MOLE_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .ROUNDS     (ROUNDS)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (start),
        .btn       (btn),
        .led       (led),
        .score     (score),
        .miss      (miss),
        .hit_pulse (hit_pulse),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    // Edges taken since reset was last released
    always @(posedge clk_in or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [15:0] lfsr_at(input int unsigned n);
        logic [15:0] v;
        v = 16'hACE1;
        for (int unsigned i = 0; i < n; i++) begin
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end
        return v;
    endfunction

    function automatic int show_len(input int r);
        int t;
`ifdef SPEEDUP_EN
        t = MOLE_TICKS - (r / 4);
        if (t < 1) t = 1;
`else
        t = MOLE_TICKS;
`endif
        return t * TICK_DIV;
    endfunction

    function automatic logic [NH-1:0] onehot(input int h);
        logic [NH-1:0] v;
        v = '0;
        v[h % NH] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_game(input int idle);
        repeat (idle) step();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_score = 0;
        exp_miss  = 0;
        prev_hole = 0;
        last_led  = '0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_score", {24'd0, score}, 32'd0);
        chk("start_miss", {24'd0, miss}, 32'd0);
        chk("start_led", {28'd0, led}, 32'd0);
    endtask

    // One round beginning just after GAP entry. hit_off/wrong_off are the
    // SHOW cycle (1-based) whose edge samples the press; 0 means none.
    task automatic play_round(input int r, input int hit_off, input int wrong_off,
                              input bit both, input bit poke_start);
        int len;
        int hole;
        logic [15:0] l;
        logic [NH-1:0] mole;
        len = show_len(r);
        for (int g = 1; g <= GAP_TICKS * TICK_DIV; g++) begin
            if (poke_start && g == 1) start = 1'b1;
            step();
            start = 1'b0;
            if (g == 1) chk("gap_hit_pulse", {31'd0, hit_pulse}, 32'd0);
            if (g < GAP_TICKS * TICK_DIV) chk("gap_led", {28'd0, led}, 32'd0);
        end
        l = lfsr_at(cyc - 1);
        hole = int'(l[1:0]);
        if (hole == prev_hole) hole = (hole + 1) % NH;
        prev_hole = hole;
        mole = onehot(hole);
        chk("show_led", {28'd0, led}, {28'd0, mole});
        chk("no_repeat", {28'd0, led & last_led}, 32'd0);
        last_led = led;
        for (int j = 1; j <= len; j++) begin
            btn = '0;
            if (j == hit_off)
                btn = mole | (both ? onehot(hole + 2) : '0);
            else if (j == wrong_off)
                btn = onehot(hole + 1);
            step();
            btn = '0;
            if (j == hit_off) begin
                exp_score++;
                chk("hit_led", {28'd0, led}, 32'd0);
                chk("hit_pulse", {31'd0, hit_pulse}, 32'd1);
                chk("hit_score", {24'd0, score}, exp_score);
                chk("hit_miss", {24'd0, miss}, exp_miss);
                break;
            end
            if (j == wrong_off || j == len) exp_miss++;
            chk("show_miss", {24'd0, miss}, exp_miss);
            chk("show_led_run", {28'd0, led}, (j == len) ? 32'd0 : {28'd0, mole});
            chk("show_no_pulse", {31'd0, hit_pulse}, 32'd0);
        end
        if (r == ROUNDS - 1) begin
            chk("end_done", {31'd0, done}, 32'd1);
            chk("end_busy", {31'd0, busy}, 32'd0);
        end else begin
            chk("mid_busy", {31'd0, busy}, 32'd1);
            chk("mid_done", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic end_game();
        step();
        chk("done_pulse", {31'd0, hit_pulse}, 32'd0);
        chk("done_led", {28'd0, led}, 32'd0);
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("done_score", {24'd0, score}, exp_score);
        chk("done_miss", {24'd0, miss}, exp_miss);
    endtask

    task automatic random_round(input int r);
        int len, h, w;
        bit both;
        len  = show_len(r);
        h    = int'($urandom_range(0, len));
        w    = 0;
        both = bit'($urandom_range(0, 1));
        if (h == 0)
            w = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 1)) : 0;
        else if (h > 1 && $urandom_range(0, 1) == 1)
            w = int'($urandom_range(1, h - 1));
        play_round(r, h, w, both, 1'b0);
    endtask

    initial begin
        // Reset held
        repeat (3) step();
        chk("rst_led", {28'd0, led}, 32'd0);
        chk("rst_score", {24'd0, score}, 32'd0);
        chk("rst_miss", {24'd0, miss}, 32'd0);
        chk("rst_pulse", {31'd0, hit_pulse}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_led", {28'd0, led}, 32'd0);

        // Game A: nobody plays
        start_game(0);
        for (int r = 0; r < ROUNDS; r++) play_round(r, 0, 0, 1'b0, 1'b0);
        end_game();
        chk("gameA_miss", {24'd0, miss}, ROUNDS);
        chk("gameA_score", {24'd0, score}, 32'd0);

        // Game B: correct press two cycles into every mole
        start_game(2);
        for (int r = 0; r < ROUNDS; r++) play_round(r, 2, 0, 1'b0, 1'b0);
        end_game();
        chk("gameB_score", {24'd0, score}, ROUNDS);
        chk("gameB_miss", {24'd0, miss}, 32'd0);

        // Game C: wrong-then-hit, simultaneous, expiry-cycle hit, start poke
        start_game(1);
        for (int r = 0; r < ROUNDS; r++) begin
            case (r)
                0: play_round(r, 3, 1, 1'b0, 1'b0);
                1: play_round(r, 2, 0, 1'b1, 1'b0);
                2: play_round(r, show_len(r), 0, 1'b0, 1'b0);
                3: play_round(r, 0, 0, 1'b0, 1'b1);
                default: random_round(r);
            endcase
        end
        end_game();

        // Randomized games
        for (int g = 0; g < 5; g++) begin
            start_game(int'($urandom_range(0, 7)));
            for (int r = 0; r < ROUNDS; r++) random_round(r);
            end_game();
        end

        // Reset in the middle of a lit mole
        start_game(3);
        play_round(0, 2, 0, 1'b0, 1'b0);
        repeat (GAP_TICKS * TICK_DIV + 3) step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_led", {28'd0, led}, 32'd0);
        chk("midrst_score", {24'd0, score}, 32'd0);
        chk("midrst_miss", {24'd0, miss}, 32'd0);
        chk("midrst_pulse", {31'd0, hit_pulse}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        step();
        rst = 1'b0;

        // Fresh game after the abort
        start_game(4);
        for (int r = 0; r < ROUNDS; r++) random_round(r);
        end_game();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
